// File: rtl/mac_pe_stw_multi_if.sv
// PE-side bus bundle: systolic datapath, test-vector load port and self-test control/status.
interface mac_pe_stw_multi_if #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned DEPTH     = 4
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Functional datapath
  logic                 op2_sel_in;
  logic                 out_sel_in;
  logic                 stat_bit_in;
  logic [1:0]           fault_inject;
  logic [WORD_SIZE-1:0] left_in;
  logic [WORD_SIZE-1:0] top_in;
  logic [WORD_SIZE-1:0] right_out;
  logic [WORD_SIZE-1:0] bottom_out;

  // Test-vector buffer write port
  logic                 tv_wr_en;
  logic [IDX_W-1:0]     tv_wr_addr;
  logic [WORD_SIZE-1:0] tv_op1;
  logic [WORD_SIZE-1:0] tv_op2;
  logic [WORD_SIZE-1:0] tv_add;
  logic [WORD_SIZE-1:0] tv_exp;

  // Self-test control and status
  logic [CNT_W-1:0]     stw_num_vec;
  logic                 stw_start;
  logic                 repair_en;
  logic                 stw_busy;
  logic                 stw_done;
  logic                 stw_pass;
  logic [CNT_W-1:0]     stw_fail_cnt;
  logic [IDX_W-1:0]     stw_fail_idx;
  logic                 bypassed;

  // Array-side driver (BIST sequencer plus neighbouring PEs)
  modport master (
    output op2_sel_in, out_sel_in, stat_bit_in, fault_inject, left_in, top_in,
    output tv_wr_en, tv_wr_addr, tv_op1, tv_op2, tv_add, tv_exp,
    output stw_num_vec, stw_start, repair_en,
    input  right_out, bottom_out,
    input  stw_busy, stw_done, stw_pass, stw_fail_cnt, stw_fail_idx, bypassed
  );

  // PE side
  modport slave (
    input  op2_sel_in, out_sel_in, stat_bit_in, fault_inject, left_in, top_in,
    input  tv_wr_en, tv_wr_addr, tv_op1, tv_op2, tv_add, tv_exp,
    input  stw_num_vec, stw_start, repair_en,
    output right_out, bottom_out,
    output stw_busy, stw_done, stw_pass, stw_fail_cnt, stw_fail_idx, bypassed
  );
endinterface

// File: rtl/mac_pe_stw_multi.sv
// Systolic MAC PE (WS/IS/OS) with a multi-vector stop-the-world self-test that
// replays buffered vectors through the live multiplier/adder and can latch the PE into bypass.
module mac_pe_stw_multi #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned DEPTH     = 4
) (
  input logic               clk,
  input logic               rst_n,
  mac_pe_stw_multi_if.slave bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W:0]   DEPTH_A = (IDX_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     fidx_q, fidx_d;
  logic                 pass_q, pass_d;
  logic [CNT_W-1:0]     fcnt_q, fcnt_d;
  logic [IDX_W-1:0]     fidx_out_q, fidx_out_d;
  logic                 byp_q, byp_d;

  logic [WORD_SIZE-1:0] left_q, top_q, stat_q, acc_q;
  logic [WORD_SIZE-1:0] tv_op1_q [DEPTH];
  logic [WORD_SIZE-1:0] tv_op2_q [DEPTH];
  logic [WORD_SIZE-1:0] tv_add_q [DEPTH];
  logic [WORD_SIZE-1:0] tv_exp_q [DEPTH];

  logic                 busy, run, tv_we, mismatch;
  logic [CNT_W-1:0]     n_clamp;
  logic [WORD_SIZE-1:0] op1, op2, add_op, mult_raw, mult_out, sum;

  assign busy = (state_q != S_IDLE);
  assign run  = (state_q == S_RUN);

  // Shared multiplier/adder: buffered vector in RUN, WS/IS or OS operands otherwise
  always_comb begin
    op1    = left_q;
    op2    = bus.stat_bit_in ? stat_q : top_q;
    add_op = bus.stat_bit_in ? top_q  : acc_q;
    if (run) begin
      op1    = tv_op1_q[idx_q];
      op2    = tv_op2_q[idx_q];
      add_op = tv_add_q[idx_q];
    end
  end

  assign mult_raw = op1 * op2;
  assign mult_out = bus.fault_inject[0] ? {WORD_SIZE{bus.fault_inject[1]}} : mult_raw;
  assign sum      = mult_out + add_op;
  assign mismatch = (sum != tv_exp_q[idx_q]);
  assign n_clamp  = (bus.stw_num_vec > DEPTH_C) ? DEPTH_C : bus.stw_num_vec;

  // Self-test sequencer: next state, working counters and result registers
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    fidx_d     = fidx_q;
    pass_d     = pass_q;
    fcnt_d     = fcnt_q;
    fidx_out_d = fidx_out_q;
    byp_d      = byp_q;
    tv_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.stw_start) begin
          if (n_clamp == '0) begin
            state_d    = S_DONE;
            pass_d     = 1'b1;
            fcnt_d     = '0;
            fidx_out_d = '0;
          end else begin
            state_d = S_RUN;
            idx_d   = '0;
            cnt_d   = '0;
            fidx_d  = '0;
            last_d  = IDX_W'(n_clamp - 1'b1);
          end
        end else begin
          // Buffer becomes read-only from the edge that accepts a start
          tv_we = bus.tv_wr_en && ({1'b0, bus.tv_wr_addr} < DEPTH_A);
        end
      end
      S_RUN: begin
        if (mismatch) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) fidx_d = idx_q;
        end
        if (idx_q == last_q) begin
          state_d    = S_DONE;
          pass_d     = (cnt_d == '0);
          fcnt_d     = cnt_d;
          fidx_out_d = fidx_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (bus.repair_en && !pass_q) byp_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      fidx_q     <= '0;
      pass_q     <= 1'b0;
      fcnt_q     <= '0;
      fidx_out_q <= '0;
      byp_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      fidx_q     <= fidx_d;
      pass_q     <= pass_d;
      fcnt_q     <= fcnt_d;
      fidx_out_q <= fidx_out_d;
      byp_q      <= byp_d;
    end
  end

  // Functional pipeline registers; frozen for the whole test so the array resumes exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q <= '0;
      top_q  <= '0;
      stat_q <= '0;
      acc_q  <= '0;
    end else if (!busy) begin
      left_q <= bus.left_in;
      top_q  <= bus.top_in;
      if (bus.op2_sel_in) stat_q <= bus.top_in;
      if (!byp_q)         acc_q  <= sum;
    end
  end

  // Test-vector buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tv_op1_q[i] <= '0;
        tv_op2_q[i] <= '0;
        tv_add_q[i] <= '0;
        tv_exp_q[i] <= '0;
      end
    end else if (tv_we) begin
      tv_op1_q[bus.tv_wr_addr] <= bus.tv_op1;
      tv_op2_q[bus.tv_wr_addr] <= bus.tv_op2;
      tv_add_q[bus.tv_wr_addr] <= bus.tv_add;
      tv_exp_q[bus.tv_wr_addr] <= bus.tv_exp;
    end
  end

  assign bus.right_out    = left_q;
  assign bus.bottom_out   = (byp_q || !bus.out_sel_in) ? top_q : acc_q;
  assign bus.stw_busy     = busy;
  assign bus.stw_done     = (state_q == S_DONE);
  assign bus.stw_pass     = pass_q;
  assign bus.stw_fail_cnt = fcnt_q;
  assign bus.stw_fail_idx = fidx_out_q;
  assign bus.bypassed     = byp_q;
endmodule

// File: tb/tb_mac_pe_stw_multi.sv
// Scoreboarded bench for mac_pe_stw_multi: functional MAC path, self-test runs, freeze, repair, reset abort.
`timescale 1ns/1ps
module tb_mac_pe_stw_multi;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic          pass;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  res_t exp_q[$];
  logic [W-1:0] m_op1 [D];
  logic [W-1:0] m_op2 [D];
  logic [W-1:0] m_add [D];
  logic [W-1:0] m_exp [D];

  always #5 clk = ~clk;

  mac_pe_stw_multi_if #(.WORD_SIZE(W), .DEPTH(D)) bus ();
  mac_pe_stw_multi #(.WORD_SIZE(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.op2_sel_in   = 1'b0;
    bus.out_sel_in   = 1'b0;
    bus.stat_bit_in  = 1'b0;
    bus.fault_inject = 2'b00;
    bus.left_in      = '0;
    bus.top_in       = '0;
    bus.tv_wr_en     = 1'b0;
    bus.tv_wr_addr   = '0;
    bus.tv_op1       = '0;
    bus.tv_op2       = '0;
    bus.tv_add       = '0;
    bus.tv_exp       = '0;
    bus.stw_num_vec  = '0;
    bus.stw_start    = 1'b0;
    bus.repair_en    = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(D); i++) begin
      m_op1[i] = '0; m_op2[i] = '0; m_add[i] = '0; m_exp[i] = '0;
    end
  endtask

  // Reference self-test result over the first n buffered vectors
  function automatic res_t model_run(input int n, input logic [1:0] fi);
    res_t         r;
    logic [2*W-1:0] p;
    logic [W-1:0] m;
    logic [W-1:0] s;
    r = '0;
    r.pass = 1'b1;
    for (int i = 0; i < n; i++) begin
      p = {{W{1'b0}}, m_op1[i]} * {{W{1'b0}}, m_op2[i]};
      m = fi[0] ? {W{fi[1]}} : p[W-1:0];
      s = m + m_add[i];
      if (s != m_exp[i]) begin
        if (r.pass) r.idx = IW'(i);
        r.pass = 1'b0;
        r.cnt  = r.cnt + 1'b1;
      end
    end
    return r;
  endfunction

  task automatic write_vec(input int a, input logic [W-1:0] o1, input logic [W-1:0] o2,
                           input logic [W-1:0] ad, input logic [W-1:0] ex);
    bus.tv_wr_en = 1'b1; bus.tv_wr_addr = IW'(a);
    bus.tv_op1 = o1; bus.tv_op2 = o2; bus.tv_add = ad; bus.tv_exp = ex;
    tick();
    bus.tv_wr_en = 1'b0;
    m_op1[a] = o1; m_op2[a] = o2; m_add[a] = ad; m_exp[a] = ex;
  endtask

  // Start a test, optionally hold start / disturb inputs while busy, then score the result
  task automatic run_stw(input string name, input int n, input bit hold, input bit scramble);
    int nc;
    int lat;
    bit frz_bad;
    res_t e;
    res_t got;
    logic [W-1:0] r0, b0, sl, st;
    nc = (n > int'(D)) ? int'(D) : n;
    exp_q.push_back(model_run(nc, bus.fault_inject));
    sl = bus.left_in;
    st = bus.top_in;
    bus.stw_num_vec = CW'(n);
    bus.stw_start   = 1'b1;
    tick();
    if (!hold) bus.stw_start = 1'b0;
    bus.tv_wr_en = scramble;
    r0 = bus.right_out;
    b0 = bus.bottom_out;
    if (scramble) begin
      bus.left_in    = W'($urandom);
      bus.top_in     = W'($urandom);
      bus.op2_sel_in = 1'b1;
      bus.tv_wr_addr = 2'd1;
      bus.tv_op1     = 16'h0101;
      bus.tv_exp     = 16'hDEAD;
    end
    frz_bad = 1'b0;
    lat = 1;
    while (bus.stw_done !== 1'b1 && lat < 20) begin
      if (bus.stw_busy !== 1'b1 || bus.right_out !== r0 || bus.bottom_out !== b0) frz_bad = 1'b1;
      tick();
      lat++;
    end
    if (bus.stw_busy !== 1'b1 || bus.right_out !== r0 || bus.bottom_out !== b0) frz_bad = 1'b1;
    checks++;
    if (lat != nc + 1) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, nc + 1);
    end
    checks++;
    if (frz_bad) begin
      failures++;
      $display("FAIL %s freeze: outputs/busy moved during test, expected held at right=%h bottom=%h", name, r0, b0);
    end
    e   = exp_q.pop_front();
    got = {bus.stw_pass, bus.stw_fail_cnt, bus.stw_fail_idx};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s result: got pass=%b cnt=%0d idx=%0d, expected pass=%b cnt=%0d idx=%0d",
               name, got.pass, got.cnt, got.idx, e.pass, e.cnt, e.idx);
    end
    bus.stw_start = 1'b0;
    bus.tv_wr_en  = 1'b0;
    if (scramble) begin
      bus.left_in    = sl;
      bus.top_in     = st;
      bus.op2_sel_in = 1'b0;
    end
    tick();
    checks++;
    if (bus.stw_done !== 1'b0 || bus.stw_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s end: got done=%b busy=%b, expected 0/0", name, bus.stw_done, bus.stw_busy);
    end
  endtask

  task automatic check_out(input string name, input logic [W-1:0] rq, input logic [W-1:0] bq);
    checks++;
    if (bus.right_out !== rq || bus.bottom_out !== bq) begin
      failures++;
      $display("FAIL %s: got right=%h bottom=%h, expected right=%h bottom=%h",
               name, bus.right_out, bus.bottom_out, rq, bq);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_clear();
    bus.left_in = 16'h0005;
    bus.top_in  = 16'h0007;
    repeat (2) tick();
    check_out("reset_out", 16'h0000, 16'h0000);
    checks++;
    if ({bus.stw_busy, bus.stw_done, bus.stw_pass, bus.stw_fail_cnt, bus.stw_fail_idx, bus.bypassed} !== '0) begin
      failures++;
      $display("FAIL reset_status: got busy=%b done=%b pass=%b cnt=%0d idx=%0d byp=%b, expected all 0",
               bus.stw_busy, bus.stw_done, bus.stw_pass, bus.stw_fail_cnt, bus.stw_fail_idx, bus.bypassed);
    end
    bus.left_in = '0;
    bus.top_in  = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ws_freeze();
    bus.top_in = 16'd3; bus.op2_sel_in = 1'b1;
    tick();
    bus.op2_sel_in = 1'b0; bus.stat_bit_in = 1'b1;
    bus.left_in = 16'd4; bus.top_in = 16'd10; bus.out_sel_in = 1'b1;
    repeat (2) tick();
    check_out("ws_mac", 16'd4, 16'd22);
    bus.out_sel_in = 1'b0;
    #1;
    check_out("ws_outsel0", 16'd4, 16'd10);
    bus.out_sel_in = 1'b1;
    #1;
    run_stw("ws_freeze", 2, 1'b0, 1'b1);
    tick();
    check_out("ws_resume", 16'd4, 16'd22);
  endtask

  task automatic test_pass();
    write_vec(0, 16'd3, 16'd5, 16'd7, 16'd22);
    write_vec(1, 16'hFFFF, 16'd2, 16'd1, 16'hFFFF);
    write_vec(2, 16'd100, 16'd100, 16'd0, 16'd10000);
    write_vec(3, 16'd0, 16'd9, 16'd4, 16'd4);
    run_stw("pass4", 4, 1'b0, 1'b1);
  endtask

  task automatic test_fault_inject();
    bus.fault_inject = 2'b01;
    run_stw("fault_stw", 2, 1'b0, 1'b0);
    checks++;
    if (bus.bypassed !== 1'b0) begin
      failures++;
      $display("FAIL fault_no_repair: got bypassed=%b, expected 0", bus.bypassed);
    end
    repeat (2) tick();
    check_out("fault_stuck0_acc", 16'd4, 16'd10);
    bus.fault_inject = 2'b11;
    tick();
    check_out("fault_stuck1_acc", 16'd4, 16'd9);
    bus.fault_inject = 2'b00;
    tick();
    check_out("fault_off_acc", 16'd4, 16'd22);
  endtask

  task automatic test_zero_clamp();
    bus.tv_wr_en = 1'b1; bus.tv_wr_addr = 2'd0;
    bus.tv_op1 = 16'd1; bus.tv_op2 = 16'd1; bus.tv_add = 16'd0; bus.tv_exp = 16'h7777;
    run_stw("zero_vec", 0, 1'b0, 1'b0);
    run_stw("clamp7_hold", 7, 1'b1, 1'b0);
  endtask

  task automatic test_fail_repair();
    write_vec(2, 16'd100, 16'd100, 16'd0, 16'd9999);
    write_vec(3, 16'd0, 16'd9, 16'd4, 16'd5);
    bus.repair_en = 1'b1;
    run_stw("fail_repair", 4, 1'b0, 1'b0);
    bus.repair_en = 1'b0;
    checks++;
    if (bus.bypassed !== 1'b1) begin
      failures++;
      $display("FAIL repair_bypass: got bypassed=%b, expected 1", bus.bypassed);
    end
    bus.top_in = 16'h1234; bus.left_in = 16'h0055; bus.out_sel_in = 1'b1;
    tick();
    check_out("bypass_pass", 16'h0055, 16'h1234);
  endtask

  task automatic test_reset_mid_run();
    bit seen_done;
    bus.stw_num_vec = 3'd4;
    bus.stw_start   = 1'b1;
    tick();
    bus.stw_start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    seen_done = bus.stw_done;
    checks++;
    if ({bus.stw_busy, bus.stw_pass, bus.stw_fail_cnt, bus.bypassed} !== '0) begin
      failures++;
      $display("FAIL abort_status: got busy=%b pass=%b cnt=%0d byp=%b, expected all 0",
               bus.stw_busy, bus.stw_pass, bus.stw_fail_cnt, bus.bypassed);
    end
    repeat (3) begin tick(); seen_done |= bus.stw_done; end
    rst_n = 1'b1;
    repeat (6) begin tick(); seen_done |= bus.stw_done; end
    checks++;
    if (seen_done) begin
      failures++;
      $display("FAIL abort_no_done: got done pulse=1, expected 0");
    end
    model_clear();
    run_stw("after_reset_zero_buf", 4, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ws_freeze();
    test_pass();
    test_fault_inject();
    test_zero_clamp();
    test_fail_repair();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
